tick_gen_multi: RTL and testbench

//  Multi-channel programmable clock-enable generator off clk10. Each channel divides clk10
//  by a runtime-loadable 26-bit divisor and emits a one-cycle tick plus a 50% square wave.

---
 rtl/tick_gen_pkg.sv | 15 +
 rtl/tick_gen_chan.sv | 150 +++++++++++++++
 rtl/tick_gen_multi.sv | 73 +++++++
 tb/tb_tick_gen_multi.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared types and constants for the multi-channel tick generator
package tick_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int DEF_CNT_W = 26;

endpackage

// File: rtl/tick_gen_chan.sv
// rtl/tick_gen_chan.sv - one tick channel: FSM, counter, shadow config, square wave
module tick_gen_chan
    import tick_gen_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = 10000000
) (
    input  logic             clk10,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    input  logic             load_mode,
    input  logic             run_en,
    input  logic             sync,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shd_div_q, shd_div_d;
    logic             mode_q, mode_d;
    logic             shd_mode_q, shd_mode_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] nxt_div;
    logic             nxt_mode;
    logic             nxt_pend;
    logic             term;

    // Next-state logic; a write arriving on the same edge as an apply point wins over the shadow
    always_comb begin
        nxt_pend   = load | pend_q;
        nxt_div    = load ? load_div  : shd_div_q;
        nxt_mode   = load ? load_mode : shd_mode_q;
        term       = (cnt_q == div_q - CNT_W'(1));
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        mode_d     = mode_q;
        shd_div_d  = shd_div_q;
        shd_mode_d = shd_mode_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        sq_d       = sq_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    div_d  = load_div;
                    mode_d = load_mode;
                end
                // A zero divisor keeps the channel parked
                if (run_en && div_d != '0) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (!run_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sq_d    = 1'b0;
                    pend_d  = 1'b0;
                    if (nxt_pend) begin
                        div_d  = nxt_div;
                        mode_d = nxt_mode;
                    end
                end else if (sync) begin
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    if (nxt_pend) begin
                        div_d  = nxt_div;
                        mode_d = nxt_mode;
                    end
                    if (div_d == '0) state_d = ST_IDLE;
                end else if (term) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    sq_d   = ~sq_q;
                    pend_d = 1'b0;
                    if (nxt_pend) begin
                        div_d  = nxt_div;
                        mode_d = nxt_mode;
                    end
                    // The tick just issued belongs to the old configuration
                    if (mode_q == MODE_ONESHOT) state_d = ST_DONE;
                    else if (div_d == '0)       state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (load) begin
                        shd_div_d  = load_div;
                        shd_mode_d = load_mode;
                        pend_d     = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (load) begin
                    div_d  = load_div;
                    mode_d = load_mode;
                end
                if (!run_en) begin
                    state_d = ST_IDLE;
                end else if (load) begin
                    state_d = (load_div != '0) ? ST_RUN : ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // State and output registers; reset also discards any pending shadow write
    always_ff @(posedge clk10) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= CNT_W'(DEFAULT_DIV);
            mode_q     <= MODE_PERIODIC;
            shd_div_q  <= '0;
            shd_mode_q <= MODE_PERIODIC;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            sq_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            mode_q     <= mode_d;
            shd_div_q  <= shd_div_d;
            shd_mode_q <= shd_mode_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            sq_q       <= sq_d;
            busy_q     <= busy_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;
    assign busy = busy_q;

endmodule

// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - multi-channel clock-enable generator; TICKGEN_SYNC_EN adds sync_in
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = DEF_CNT_W,
    parameter int  DEFAULT_DIV = 10000000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk10,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_ack,
    input  logic [NUM_CH-1:0] run_en,
`ifdef TICKGEN_SYNC_EN
    input  logic              sync_in,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] busy
);

    localparam int CH_W1 = CH_W + 1;

    logic [NUM_CH-1:0] load;
    logic              sync_w;
    logic              cfg_ack_q, cfg_ack_d;

`ifdef TICKGEN_SYNC_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    // Decode the write into per-channel load strobes; an out-of-range index matches nothing
    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_wr && ({1'b0, cfg_ch} == CH_W1'(i))) load[i] = 1'b1;
        end
        cfg_ack_d = |load;
    end

    // Acknowledge accepted writes one cycle later
    always_ff @(posedge clk10) begin
        if (!reset) cfg_ack_q <= 1'b0;
        else        cfg_ack_q <= cfg_ack_d;
    end

    assign cfg_ack = cfg_ack_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_gen_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk10     (clk10),
            .reset     (reset),
            .load      (load[g]),
            .load_div  (cfg_div),
            .load_mode (cfg_mode),
            .run_en    (run_en[g]),
            .sync      (sync_w),
            .tick      (tick[g]),
            .sq        (sq[g]),
            .busy      (busy[g])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb/tb_tick_gen_multi.sv - directed self-checking bench for tick_gen_multi
module tb_tick_gen_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 26;
    localparam int DEF_D  = 6;

    logic              clk10;
    logic              reset;
    logic              cfg_wr;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic              cfg_ack;
    logic [NUM_CH-1:0] run_en;
    logic              sync_in;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] busy;

    int n_checks;
    int n_fail;

    logic [NUM_CH-1:0] tick_h [0:31];
    logic [NUM_CH-1:0] sq_h   [0:31];

    tick_gen_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_D)
    ) dut (
        .clk10    (clk10),
        .reset    (reset),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .cfg_ack  (cfg_ack),
        .run_en   (run_en),
`ifdef TICKGEN_SYNC_EN
        .sync_in  (sync_in),
`endif
        .tick     (tick),
        .sq       (sq),
        .busy     (busy)
    );

    initial clk10 = 1'b0;
    always #5 clk10 = ~clk10;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk10);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int d, input logic mode);
        cfg_wr   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_div  = CNT_W'(d);
        cfg_mode = mode;
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            tick_h[i] = tick;
            sq_h[i]   = sq;
        end
    endtask

    function automatic logic [31:0] hist(input int ch, input int n, input bit use_sq);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = use_sq ? sq_h[i][ch] : tick_h[i][ch];
        return m;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_mode = 1'b0;
        run_en   = '0;
        sync_in  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_sq", 32'(sq), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(cfg_ack), 0);
        reset = 1'b1;
        step();

        // 1: ch0 D=4 periodic
        cfg_write(0, 4, 1'b0);
        chk("t1_ack", 32'(cfg_ack), 1);
        run_en[0] = 1'b1;
        step();
        chk("t1_ack_low", 32'(cfg_ack), 0);
        chk("t1_busy", 32'(busy[0]), 1);
        capture(12);
        chk("t1_tick", hist(0, 12, 1'b0), 32'h888);
        chk("t1_sq", hist(0, 12, 1'b1), 32'h878);

        // 2: ch1 D=3 one-shot, then rearm by write
        cfg_write(1, 3, 1'b1);
        run_en[1] = 1'b1;
        step();
        capture(8);
        chk("t2_tick", hist(1, 8, 1'b0), 32'h004);
        chk("t2_done_busy", 32'(busy[1]), 0);
        cfg_write(1, 3, 1'b1);
        chk("t2_rearm_busy", 32'(busy[1]), 1);
        capture(6);
        chk("t2_rearm_tick", hist(1, 6, 1'b0), 32'h004);

        // 3: ch2 D=10 running, write D=5 at cnt=4
        cfg_write(2, 10, 1'b0);
        run_en[2] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        cfg_write(2, 5, 1'b0);
        chk("t3_ack", 32'(cfg_ack), 1);
        capture(20);
        chk("t3_tick", hist(2, 20, 1'b0), 32'h84210);

        // 4: D=1, D=0, out-of-range channel
        run_en[0] = 1'b0;
        step();
        chk("t4_stop_busy", 32'(busy[0]), 0);
        chk("t4_stop_sq", 32'(sq[0]), 0);
        run_en[0] = 1'b1;
        cfg_write(0, 1, 1'b0);
        chk("t4_d1_busy", 32'(busy[0]), 1);
        capture(4);
        chk("t4_d1_tick", hist(0, 4, 1'b0), 32'hF);
        chk("t4_d1_sq", hist(0, 4, 1'b1), 32'h5);
        run_en[0] = 1'b0;
        step();
        run_en[0] = 1'b1;
        cfg_write(0, 0, 1'b0);
        capture(5);
        chk("t4_d0_tick", hist(0, 5, 1'b0), 32'h0);
        chk("t4_d0_busy", 32'(busy[0]), 0);
        cfg_write(3, 2, 1'b0);
        chk("t4_oor_ack", 32'(cfg_ack), 0);
        step();
        step();
        chk("t4_oor_busy", 32'(busy), 32'h4);

        // 5: reset mid-count with a pending shadow write
        cfg_write(0, 10, 1'b0);
        chk("t5_busy", 32'(busy[0]), 1);
        for (int i = 0; i < 4; i++) step();
        cfg_write(0, 2, 1'b0);
        step();
        step();
        reset    = 1'b0;
        cfg_wr   = 1'b1;
        cfg_ch   = 2'd1;
        cfg_div  = CNT_W'(3);
        cfg_mode = 1'b0;
        step();
        cfg_wr   = 1'b0;
        chk("t5_tick", 32'(tick), 0);
        chk("t5_sq", 32'(sq), 0);
        chk("t5_busy0", 32'(busy), 0);
        chk("t5_ack", 32'(cfg_ack), 0);
        reset = 1'b1;
        step();
        capture(12);
        chk("t5_def_ch0", hist(0, 12, 1'b0), 32'h820);
        chk("t5_def_ch1", hist(1, 12, 1'b0), 32'h820);

`ifdef TICKGEN_SYNC_EN
        // 6: sync pulse phase-aligns ch0 (D=4) and ch1 (D=6)
        run_en = 3'b100;
        step();
        cfg_write(0, 4, 1'b0);
        cfg_write(1, 6, 1'b0);
        run_en = 3'b111;
        step();
        for (int i = 0; i < 3; i++) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        chk("t6_sync_tick", 32'(tick[1:0]), 0);
        capture(8);
        chk("t6_ch0", hist(0, 8, 1'b0), 32'h88);
        chk("t6_ch1", hist(1, 8, 1'b0), 32'h20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
